a0_trace_buffer: RTL and testbench

//   Downstream consumer of the CPU a0 result bus. Samples a0 every cycle and records each new value

---
 rtl/a0_trace_buffer_pkg.sv | 28 ++
 rtl/a0_trace_buffer_if.sv | 34 +++
 rtl/a0_trace_buffer_sync_fifo.sv | 72 +++++++
 rtl/a0_trace_buffer.sv | 75 +++++++
 tb/tb_a0_trace_buffer.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/a0_trace_buffer_pkg.sv
// ============================================================================
// a0_trace_buffer_pkg : shared types, widths and helpers for the a0 trace buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

package a0_trace_buffer_pkg;

    localparam int DATA_W     = 32;
    localparam int TS_W_DFLT  = 16;
    localparam int OVF_W      = 8;

    typedef logic [DATA_W-1:0] DATA_BUS;

    // Entry layout at the default timestamp width; the top re-declares the
    // same layout against its own TS_WIDTH parameter.
    typedef struct packed {
        logic [TS_W_DFLT-1:0] ts;
        DATA_BUS              data;
    } trace_entry_t;

    function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
        return (v == {OVF_W{1'b1}}) ? v : v + OVF_W'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/a0_trace_buffer_if.sv
// ============================================================================
// a0_trace_buffer_if : capture input plus valid/ready drain port and status
// Revision: 1.0
// ============================================================================
`default_nettype none

interface a0_trace_buffer_if
    import a0_trace_buffer_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int TS_WIDTH = 16
);
    logic                       en;
    DATA_BUS                    a0;
    logic                       out_valid;
    logic                       out_ready;
    DATA_BUS                    out_data;
    logic [TS_WIDTH-1:0]        out_ts;
    logic [$clog2(DEPTH):0]     count;
    logic                       full;
    logic [OVF_W-1:0]           overflow_cnt;

    modport slave (
        input  en, a0, out_ready,
        output out_valid, out_data, out_ts, count, full, overflow_cnt
    );

    modport master (
        output en, a0, out_ready,
        input  out_valid, out_data, out_ts, count, full, overflow_cnt
    );
endinterface

`default_nettype wire

// File: rtl/a0_trace_buffer_sync_fifo.sv
// ============================================================================
// a0_trace_buffer_sync_fifo : first-word-fall-through FIFO with push/pop
//                             arbitration and drop indication
// Revision: 1.0
// ============================================================================
`default_nettype none

module a0_trace_buffer_sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 16
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     wr_en,
    input  wire logic [WIDTH-1:0]         wr_data,
    input  wire logic                     rd_ready,
    output logic                          rd_valid,
    output logic      [WIDTH-1:0]         rd_data,
    output logic                          full,
    output logic      [$clog2(DEPTH):0]   count,
    output logic                          dropped
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             empty;
    logic             push;
    logic             pop;
    logic [CW-1:0]    count_nxt;

    assign empty    = (count == '0);
    assign rd_valid = ~empty;
    assign pop      = rd_valid & rd_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign push     = wr_en & (~full | pop);
    assign dropped  = wr_en & full & ~pop;
    assign rd_data  = empty ? '0 : mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == FULL_CNT);
        end
    end

endmodule

`default_nettype wire

// File: rtl/a0_trace_buffer.sv
// ============================================================================
// a0_trace_buffer : timestamps a0 updates into a FIFO drained by a slow sink,
//                   counting captures dropped while full
// Revision: 1.0
// ============================================================================
`default_nettype none

module a0_trace_buffer
    import a0_trace_buffer_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int TS_WIDTH    = 16,
    parameter bit CAPTURE_ALL = 1'b0
) (
    input wire logic         clk,
    input wire logic         rst,
    a0_trace_buffer_if.slave bus
);
    typedef struct packed {
        logic [TS_WIDTH-1:0] ts;
        DATA_BUS             data;
    } entry_t;

    logic [TS_WIDTH-1:0] ts;
    DATA_BUS             prev_a0;
    logic                seen;
    logic                capture;
    logic                drop;
    logic [OVF_W-1:0]    ovf_cnt;
    entry_t              wr_entry;
    entry_t              rd_entry;

    assign capture  = bus.en & (CAPTURE_ALL | ~seen | (bus.a0 != prev_a0));
    assign wr_entry = '{ts: ts, data: bus.a0};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts      <= '0;
            prev_a0 <= '0;
            seen    <= 1'b0;
            ovf_cnt <= '0;
        end else begin
            if (bus.en) begin
                ts      <= ts + TS_WIDTH'(1);
                prev_a0 <= bus.a0;
            end
            // Dropping en forgets history so re-enable always logs one sample.
            seen <= bus.en;
            if (drop) ovf_cnt <= sat_inc(ovf_cnt);
        end
    end

    a0_trace_buffer_sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (capture),
        .wr_data  (wr_entry),
        .rd_ready (bus.out_ready),
        .rd_valid (bus.out_valid),
        .rd_data  (rd_entry),
        .full     (bus.full),
        .count    (bus.count),
        .dropped  (drop)
    );

    assign bus.out_data     = rd_entry.data;
    assign bus.out_ts       = rd_entry.ts;
    assign bus.overflow_cnt = ovf_cnt;

endmodule

`default_nettype wire

// File: tb/tb_a0_trace_buffer.sv
// ============================================================================
// tb_a0_trace_buffer : directed vector table plus corner-case sequences
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_a0_trace_buffer;
    import a0_trace_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    a0_trace_buffer_if #(.DEPTH(4),  .TS_WIDTH(16)) bus_a ();
    a0_trace_buffer_if #(.DEPTH(16), .TS_WIDTH(4))  bus_b ();

    a0_trace_buffer #(.DEPTH(4), .TS_WIDTH(16), .CAPTURE_ALL(1'b0)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a.slave)
    );
    a0_trace_buffer #(.DEPTH(16), .TS_WIDTH(4), .CAPTURE_ALL(1'b1)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b.slave)
    );

    typedef struct {
        logic        rs;
        logic        en;
        logic [31:0] a0;
        logic        rdy;
        logic        v;
        logic [31:0] d;
        logic [15:0] ts;
        logic [2:0]  cnt;
        logic        full;
        logic [7:0]  ovf;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic rs, input logic en, input logic [31:0] a0, input logic rdy,
                       input logic v, input logic [31:0] d, input logic [15:0] ts,
                       input logic [2:0] cnt, input logic full, input logic [7:0] ovf);
        vec_t t;
        t.rs = rs; t.en = en; t.a0 = a0; t.rdy = rdy;
        t.v = v; t.d = d; t.ts = ts; t.cnt = cnt; t.full = full; t.ovf = ovf;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic pulse_reset();
        bus_a.en = 1'b0; bus_b.en = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // {valid, data, ts, count, full, ovf} packed into one word for dut_a
    function automatic logic [63:0] pack_a();
        return {3'b0, bus_a.out_valid, bus_a.out_data, bus_a.out_ts[7:0], 1'b0,
                bus_a.count, bus_a.full, 3'b0, bus_a.overflow_cnt[7:0]};
    endfunction

    function automatic logic [63:0] pack_exp(input vec_t t);
        return {3'b0, t.v, t.d, t.ts[7:0], 1'b0, t.cnt, t.full, 3'b0, t.ovf};
    endfunction

    initial begin
        bus_a.en = 1'b0; bus_a.a0 = '0; bus_a.out_ready = 1'b0;
        bus_b.en = 1'b0; bus_b.a0 = '0; bus_b.out_ready = 1'b0;

        // repeated value recorded once
        add(1, 1, 32'h5, 0,  1, 32'h5, 0, 1, 0, 0);
        for (int i = 0; i < 9; i++) add(0, 1, 32'h5, 0,  1, 32'h5, 0, 1, 0, 0);
        add(0, 0, 32'h0, 1,  0, 32'h0, 0, 0, 0, 0);
        // change-only capture with sink ready
        add(1, 1, 32'h1, 1,  1, 32'h1, 0, 1, 0, 0);
        add(0, 1, 32'h2, 1,  1, 32'h2, 1, 1, 0, 0);
        add(0, 1, 32'h2, 1,  0, 32'h0, 0, 0, 0, 0);
        add(0, 1, 32'h3, 1,  1, 32'h3, 3, 1, 0, 0);
        add(0, 0, 32'h0, 1,  0, 32'h0, 0, 0, 0, 0);
        // fill, overflow, push+pop at full, drain
        add(1, 1, 32'd10, 0, 1, 32'd10, 0, 1, 0, 0);
        add(0, 1, 32'd11, 0, 1, 32'd10, 0, 2, 0, 0);
        add(0, 1, 32'd12, 0, 1, 32'd10, 0, 3, 0, 0);
        add(0, 1, 32'd13, 0, 1, 32'd10, 0, 4, 1, 0);
        add(0, 1, 32'd14, 0, 1, 32'd10, 0, 4, 1, 1);
        add(0, 1, 32'd15, 0, 1, 32'd10, 0, 4, 1, 2);
        add(0, 1, 32'd16, 1, 1, 32'd11, 1, 4, 1, 2);
        add(0, 0, 32'd0,  1, 1, 32'd12, 2, 3, 0, 2);
        add(0, 0, 32'd0,  1, 1, 32'd13, 3, 2, 0, 2);
        add(0, 0, 32'd0,  1, 1, 32'd16, 6, 1, 0, 2);
        add(0, 0, 32'd0,  1, 0, 32'd0,  0, 0, 0, 2);

        #2;
        check("reset_state", pack_a(), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rs) pulse_reset();
            bus_a.en = vecs[i].en; bus_a.a0 = vecs[i].a0; bus_a.out_ready = vecs[i].rdy;
            step();
            check($sformatf("vec%0d", i), pack_a(), pack_exp(vecs[i]));
        end

        // overflow counter saturates rather than wrapping
        pulse_reset();
        bus_a.out_ready = 1'b0;
        bus_a.en = 1'b1;
        for (int i = 0; i < 264; i++) begin
            bus_a.a0 = 32'(i + 1);
            step();
        end
        check("ovf_saturate", {48'b0, 5'(bus_a.count), 3'b0, bus_a.overflow_cnt}, {48'b0, 5'd4, 3'b0, 8'd255});
        bus_a.en = 1'b0; bus_a.out_ready = 1'b1;
        step();
        bus_a.out_ready = 1'b0;
        check("pre_reset_count", {61'b0, bus_a.count}, 64'd3);

        // asynchronous reset mid-cycle clears everything without a clock edge
        #2 rst = 1'b0;
        #1;
        check("async_reset", pack_a(), 64'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        bus_a.en = 1'b1; bus_a.a0 = 32'h7;
        step();
        check("post_reset_capture", {bus_a.out_data, bus_a.out_ts, 13'b0, bus_a.count},
              {32'h7, 16'd0, 13'b0, 3'd1});
        bus_a.en = 1'b0;

        // capture-all with a 4-bit timestamp: wraps and freezes while disabled
        pulse_reset();
        bus_b.out_ready = 1'b1;
        bus_b.a0 = 32'h99;
        bus_b.en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("ts_seq%0d", i), {59'b0, bus_b.out_valid, bus_b.out_ts},
                  {59'b0, 1'b1, 4'(i % 16)});
        end
        bus_b.en = 1'b0;
        step();
        step();
        check("ts_disabled_empty", {63'b0, bus_b.out_valid}, 64'd0);
        bus_b.en = 1'b1;
        step();
        check("ts_frozen_a", {59'b0, bus_b.out_valid, bus_b.out_ts}, {59'b0, 1'b1, 4'd4});
        step();
        check("ts_frozen_b", {59'b0, bus_b.out_valid, bus_b.out_ts}, {59'b0, 1'b1, 4'd5});
        bus_b.en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
